// File: rtl/pg_alu_ctrl.sv
// Power-gated ALU controller: sequences power/isolation of the ALU domain and
// runs one multi-cycle operation at a time into an always-on retained result.
module pg_alu_ctrl #(
    parameter int WIDTH      = 16,
    parameter int EXEC_CYC   = 2,
    parameter int PWR_UP_CYC = 4,
    parameter int ISO_DLY    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    input  logic             start,
    input  logic             sleep_req,
    input  logic             wake_req,
    output logic             alu_pwr_en,
    output logic             iso_en,
    output logic             busy,
    output logic             done,
    output logic             rej,
    output logic             err,
    output logic [2:0]       pwr_state,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_PWR_UP = 3'd1,
        S_IDLE   = 3'd2,
        S_EXEC   = 3'd3,
        S_ISO_ON = 3'd4
    } state_t;

    localparam int SHW     = $clog2(WIDTH);
    localparam int CNT_MAX = (EXEC_CYC > PWR_UP_CYC)
                           ? ((EXEC_CYC > ISO_DLY) ? EXEC_CYC : ISO_DLY)
                           : ((PWR_UP_CYC > ISO_DLY) ? PWR_UP_CYC : ISO_DLY);
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_pend;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] w_alu;
    logic             w_bad_op;
    logic             w_exec_fin;

    assign w_exec_fin = (r_state == S_EXEC) && (r_cnt == CW'(EXEC_CYC - 1));
    assign pwr_state  = r_state;

    // NOTE: every variable written here is given a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_OFF:    if (wake_req) w_next = S_PWR_UP;
            S_PWR_UP: if (r_cnt == CW'(PWR_UP_CYC - 1)) w_next = S_IDLE;
            S_IDLE: begin
                if (start)          w_next = S_EXEC;
                else if (sleep_req) w_next = S_ISO_ON;
            end
            S_EXEC:   if (w_exec_fin) w_next = (r_pend || sleep_req) ? S_ISO_ON : S_IDLE;
            S_ISO_ON: if (r_cnt == CW'(ISO_DLY - 1)) w_next = S_OFF;
            default:  w_next = S_OFF;
        endcase
    end

    always_comb begin
        w_alu    = '0;
        w_bad_op = 1'b0;
        case (r_op)
            4'd0:    w_alu = r_a + r_b;
            4'd1:    w_alu = r_a - r_b;
            4'd2:    w_alu = r_a & r_b;
            4'd3:    w_alu = r_a | r_b;
            4'd4:    w_alu = r_a ^ r_b;
            4'd5:    w_alu = r_a << r_b[SHW-1:0];
            4'd6:    w_alu = r_a >> r_b[SHW-1:0];
            4'd7:    w_alu = r_a;
            default: w_bad_op = 1'b1;
        endcase
    end

    // NOTE: operand registers carry no reset; they are only read after a start has loaded them.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start) begin
            r_a  <= a;
            r_b  <= b;
            r_op <= opcode;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_OFF;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            result     <= '0;
            alu_pwr_en <= 1'b0;
            iso_en     <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            rej        <= 1'b0;
            err        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state inside {S_PWR_UP, S_EXEC, S_ISO_ON})
                r_cnt <= r_cnt + CW'(1);

            // Entry into ISO_ON consumes the pending sleep, even if one arrives that same cycle.
            if (w_next == S_ISO_ON && r_state != S_ISO_ON)
                r_pend <= 1'b0;
            else if ((r_state == S_IDLE && start && sleep_req) || (r_state == S_EXEC && sleep_req))
                r_pend <= 1'b1;

            if (w_exec_fin)
                result <= w_alu;
            done <= w_exec_fin;
            err  <= w_exec_fin && w_bad_op;
            rej  <= start && (r_state != S_IDLE);

            alu_pwr_en <= (w_next != S_OFF);
            iso_en     <= (w_next inside {S_OFF, S_PWR_UP, S_ISO_ON});
            busy       <= (w_next == S_EXEC);
        end
    end

endmodule

// File: tb/tb_pg_alu_ctrl.sv
// Directed plus randomized bench for pg_alu_ctrl against a cycle-level
// behavioural model of the power sequence and the ALU arithmetic.
module tb_pg_alu_ctrl;

    localparam int W  = 16;
    localparam int EC = 2;
    localparam int PC = 4;
    localparam int ID = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   opcode;
    logic         start;
    logic         sleep_req;
    logic         wake_req;
    logic         alu_pwr_en;
    logic         iso_en;
    logic         busy;
    logic         done;
    logic         rej;
    logic         err;
    logic [2:0]   pwr_state;
    logic [W-1:0] result;

    int total = 0;
    int bad   = 0;

    pg_alu_ctrl #(.WIDTH(W), .EXEC_CYC(EC), .PWR_UP_CYC(PC), .ISO_DLY(ID)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .opcode     (opcode),
        .start      (start),
        .sleep_req  (sleep_req),
        .wake_req   (wake_req),
        .alu_pwr_en (alu_pwr_en),
        .iso_en     (iso_en),
        .busy       (busy),
        .done       (done),
        .rej        (rej),
        .err        (err),
        .pwr_state  (pwr_state),
        .result     (result)
    );

    always #5 clk = ~clk;

    // Model: a phase name plus a countdown of cycles left in that phase.
    typedef enum {PH_OFF, PH_RAMP, PH_READY, PH_RUN, PH_ISOLATE} phase_t;

    phase_t          m_ph;
    int              m_left;
    bit              m_pend;
    longint unsigned m_res;
    longint unsigned m_a;
    longint unsigned m_b;
    int              m_op;
    bit              m_done;
    bit              m_err;
    bit              m_rej;

    function automatic longint unsigned alu_ref(longint unsigned x, longint unsigned y, int op);
        longint unsigned modv = 64'd1 << W;
        longint unsigned pw   = 64'd1 << (y % W);
        case (op)
            0:       return (x + y) % modv;
            1:       return (x + modv - y) % modv;
            2:       return x & y;
            3:       return x | y;
            4:       return x ^ y;
            5:       return (x * pw) % modv;
            6:       return x / pw;
            7:       return x;
            default: return 0;
        endcase
    endfunction

    function automatic int phase_code(phase_t p);
        case (p)
            PH_OFF:     return 0;
            PH_RAMP:    return 1;
            PH_READY:   return 2;
            PH_RUN:     return 3;
            default:    return 4;
        endcase
    endfunction

    task automatic model_step();
        if (rst) begin
            m_ph = PH_OFF; m_left = 0; m_pend = 0; m_res = 0;
            m_done = 0; m_err = 0; m_rej = 0;
            return;
        end
        m_done = 0;
        m_err  = 0;
        m_rej  = start && (m_ph != PH_READY);
        case (m_ph)
            PH_OFF: if (wake_req) begin m_ph = PH_RAMP; m_left = PC; end
            PH_RAMP: begin
                m_left--;
                if (m_left == 0) m_ph = PH_READY;
            end
            PH_READY: begin
                if (start) begin
                    m_a = a; m_b = b; m_op = int'(opcode);
                    m_ph = PH_RUN; m_left = EC;
                    if (sleep_req) m_pend = 1;
                end else if (sleep_req) begin
                    m_ph = PH_ISOLATE; m_left = ID;
                end
            end
            PH_RUN: begin
                if (sleep_req) m_pend = 1;
                m_left--;
                if (m_left == 0) begin
                    m_res  = alu_ref(m_a, m_b, m_op);
                    m_done = 1;
                    m_err  = (m_op > 7);
                    if (m_pend) begin
                        m_ph = PH_ISOLATE; m_left = ID; m_pend = 0;
                    end else begin
                        m_ph = PH_READY;
                    end
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_ph = PH_OFF;
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model on the edge, then compare every output 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("pwr_state",  64'(pwr_state),  64'(phase_code(m_ph)));
        check("alu_pwr_en", 64'(alu_pwr_en), 64'(m_ph != PH_OFF));
        check("iso_en",     64'(iso_en),     64'(m_ph inside {PH_OFF, PH_RAMP, PH_ISOLATE}));
        check("busy",       64'(busy),       64'(m_ph == PH_RUN));
        check("done",       64'(done),       64'(m_done));
        check("err",        64'(err),        64'(m_err));
        check("rej",        64'(rej),        64'(m_rej));
        check("result",     64'(result),     m_res);
    endtask

    task automatic power_up();
        wake_req = 1'b1;
        cycle();
        wake_req = 1'b0;
        repeat (PC) cycle();
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; opcode = '0;
        start = 1'b0; sleep_req = 1'b0; wake_req = 1'b0;
        m_ph = PH_OFF; m_left = 0; m_pend = 0; m_res = 0;
        m_a = 0; m_b = 0; m_op = 0; m_done = 0; m_err = 0; m_rej = 0;

        // Reset state
        cycle(); cycle();
        rst = 1'b0;
        check("rst_state", 64'(pwr_state), 64'd0);
        check("rst_iso",   64'(iso_en),    64'd1);
        check("rst_pwr",   64'(alu_pwr_en), 64'd0);
        check("rst_res",   64'(result),    64'd0);

        // Wake: four PWR_UP cycles, then IDLE
        wake_req = 1'b1;
        cycle();
        wake_req = 1'b0;
        check("ramp_state0", 64'(pwr_state), 64'd1);
        for (int i = 1; i < 4; i++) begin
            cycle();
            check("ramp_state", 64'(pwr_state), 64'd1);
            check("ramp_iso",   64'(iso_en),    64'd1);
        end
        cycle();
        check("idle_state", 64'(pwr_state), 64'd2);
        check("idle_iso",   64'(iso_en),    64'd0);
        check("idle_pwr",   64'(alu_pwr_en), 64'd1);

        // ADD with carry dropped
        a = 16'hFFFF; b = 16'h0001; opcode = 4'd0; start = 1'b1;
        cycle();
        start = 1'b0;
        check("add_busy1", 64'(busy), 64'd1);
        cycle();
        check("add_busy2", 64'(busy), 64'd1);
        cycle();
        check("add_done", 64'(done),   64'd1);
        check("add_res",  64'(result), 64'h0000);
        check("add_err",  64'(err),    64'd0);

        // SHL with sleep raised in the last EXEC cycle, then retention through OFF
        a = 16'h00F0; b = 16'h0004; opcode = 4'd5; start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        sleep_req = 1'b1;
        cycle();
        sleep_req = 1'b0;
        check("shl_done",  64'(done),      64'd1);
        check("shl_res",   64'(result),    64'h0F00);
        check("shl_iso1",  64'(pwr_state), 64'd4);
        cycle();
        check("shl_iso2",  64'(pwr_state), 64'd4);
        cycle();
        check("shl_off",   64'(pwr_state), 64'd0);
        check("shl_keep",  64'(result),    64'h0F00);

        // In OFF: sleep ignored, start rejected
        sleep_req = 1'b1; start = 1'b1;
        cycle();
        sleep_req = 1'b0; start = 1'b0;
        check("off_stay", 64'(pwr_state), 64'd0);
        check("off_rej",  64'(rej),       64'd1);

        // Unsupported opcode, plus start during EXEC
        power_up();
        a = 16'h1234; b = 16'h0003; opcode = 4'd9; start = 1'b1;
        cycle();
        a = 16'h0001; b = 16'h0001; opcode = 4'd0;
        cycle();
        start = 1'b0;
        check("exec_rej", 64'(rej), 64'd1);
        cycle();
        check("bad_done", 64'(done),   64'd1);
        check("bad_err",  64'(err),    64'd1);
        check("bad_res",  64'(result), 64'h0000);
        repeat (3) begin
            cycle();
            check("no_second_op", 64'(done), 64'd0);
        end

        // start and sleep together in IDLE: run, then ISO_ON right after done
        a = 16'h0005; b = 16'h0007; opcode = 4'd1; start = 1'b1; sleep_req = 1'b1;
        cycle();
        start = 1'b0; sleep_req = 1'b0;
        check("both_exec", 64'(pwr_state), 64'd3);
        cycle();
        cycle();
        check("both_done", 64'(done),      64'd1);
        check("both_res",  64'(result),    64'hFFFE);
        check("both_iso",  64'(pwr_state), 64'd4);
        repeat (ID) cycle();

        // Reset in the first EXEC cycle
        power_up();
        a = 16'h0001; b = 16'h0002; opcode = 4'd0; start = 1'b1;
        cycle();
        start = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_state", 64'(pwr_state), 64'd0);
        check("mid_rst_pwr",   64'(alu_pwr_en), 64'd0);
        check("mid_rst_iso",   64'(iso_en),    64'd1);
        check("mid_rst_res",   64'(result),    64'd0);
        check("mid_rst_done",  64'(done),      64'd0);
        repeat (3) cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            wake_req  = ($urandom_range(0, 5) == 0);
            sleep_req = ($urandom_range(0, 9) == 0);
            start     = ($urandom_range(0, 2) == 0);
            a         = W'($urandom);
            b         = W'($urandom);
            opcode    = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
